uart_tx_sched: RTL and testbench

- Transmit-side scheduler for the multiplayer UART link.
- Accepts message requests from three game sources (keeper position, shot event, score update) plus an internal heartbeat.
- Arbitrates between them round-robin and serialises each message as a framed byte packet into the UART TX FIFO via wr_uart/w_data, honouring tx_full.
- Sits between gloves/ball/score control and the uart instance in top_game.

---
 rtl/uart_tx_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: transmit scheduler for the multiplayer UART link.
// Collects keeper / shot / score requests plus a periodic heartbeat.
// Grants them round-robin and writes each one as a framed byte packet into
// the UART TX FIFO, stalling while tx_full is high.
// Optional build macro UART_TX_CHKSUM_EN appends an XOR checksum byte to
// every packet. The header length field does not count this byte.
module uart_tx_sched #(
  parameter int HB_PERIOD = 50_000_000,
  parameter int OVR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             keeper_req,
  input  logic [11:0]      keeper_x,
  input  logic [11:0]      keeper_y,
  input  logic             shot_req,
  input  logic [11:0]      shot_x,
  input  logic [11:0]      shot_y,
  input  logic             score_req,
  input  logic [2:0]       score_player,
  input  logic [2:0]       score_enemy,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [7:0]       w_data,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

`ifdef UART_TX_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, SEND, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

  state_t           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [11:0]      kx_q, kx_d, ky_q, ky_d;
  logic [11:0]      sx_q, sx_d, sy_q, sy_d;
  logic [2:0]       sp_q, sp_d, se_q, se_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       len_q, len_d;
  logic [3:0][7:0]  pkt_q, pkt_d;
`ifdef UART_TX_CHKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic [OVR_W+1:0] ovr_sum;
  logic [1:0]       ovr_inc;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             hb_fire;
  logic [3:0]       req_vec;
  logic [1:0]       gnt_idx;
  logic             gnt_found;
  logic             gnt_vld;

  // Packet header byte: fixed 0xA nibble, message type, payload length.
  function automatic logic [7:0] hdr(input logic [1:0] typ, input logic [1:0] len);
    return {4'hA, typ, len};
  endfunction

  // Heartbeat timer: runs only while the link is enabled, fires on its last count.
  always_comb begin
    hb_fire = 1'b0;
    hb_d    = '0;
    if (enable && (HB_PERIOD != 0)) begin
      if (hb_q == HB_W'(HB_PERIOD - 1)) hb_fire = 1'b1;
      else                              hb_d    = hb_q + 1'b1;
    end
  end

  // Round-robin pick: first pending source at or after the rr pointer.
  always_comb begin
    gnt_idx   = rr_q;
    gnt_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!gnt_found && pend_q[rr_q + 2'(k)]) begin
        gnt_idx   = rr_q + 2'(k);
        gnt_found = 1'b1;
      end
    end
    gnt_vld = (state_q == LOAD) && gnt_found;
  end

  // Request capture: newest data wins; an overwrite of an ungranted pending message counts as overrun.
  always_comb begin
    req_vec = {hb_fire, score_req & enable, shot_req & enable, keeper_req & enable};
    pend_d  = pend_q;
    ovr_inc = 2'd0;
    kx_d = kx_q;  ky_d = ky_q;
    sx_d = sx_q;  sy_d = sy_q;
    sp_d = sp_q;  se_d = se_q;
    for (int i = 0; i < 4; i++) begin
      if (req_vec[i]) begin
        pend_d[i] = 1'b1;
        // Heartbeat (i=3) collisions are dropped silently, never counted.
        if ((i < 3) && pend_q[i] && !(gnt_vld && (gnt_idx == 2'(i))))
          ovr_inc = ovr_inc + 2'd1;
      end else if (gnt_vld && (gnt_idx == 2'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
    if (req_vec[0]) begin kx_d = keeper_x;     ky_d = keeper_y;    end
    if (req_vec[1]) begin sx_d = shot_x;       sy_d = shot_y;      end
    if (req_vec[2]) begin sp_d = score_player; se_d = score_enemy; end
    ovr_sum = {2'b00, ovr_q} + {OVR_W'(0), ovr_inc};
    ovr_d   = (|ovr_sum[OVR_W+1:OVR_W]) ? '1 : ovr_sum[OVR_W-1:0];
  end

  // Packet FSM: load a snapshot of the granted message, then stream its bytes as the FIFO accepts them.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pkt_d   = pkt_q;
`ifdef UART_TX_CHKSUM_EN
    chk_d   = chk_q;
`endif
    wr_uart = 1'b0;
    w_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (|pend_q) state_d = LOAD;
      end
      LOAD: begin
        rr_d    = gnt_idx + 2'd1;
        idx_d   = 2'd0;
        state_d = SEND;
        pkt_d   = '0;
        case (gnt_idx)
          2'd0: begin
            len_d    = 2'd3;
            pkt_d[0] = hdr(2'd0, 2'd3);
            pkt_d[1] = kx_q[11:4];
            pkt_d[2] = {kx_q[3:0], ky_q[11:8]};
            pkt_d[3] = ky_q[7:0];
          end
          2'd1: begin
            len_d    = 2'd3;
            pkt_d[0] = hdr(2'd1, 2'd3);
            pkt_d[1] = sx_q[11:4];
            pkt_d[2] = {sx_q[3:0], sy_q[11:8]};
            pkt_d[3] = sy_q[7:0];
          end
          2'd2: begin
            len_d    = 2'd1;
            pkt_d[0] = hdr(2'd2, 2'd1);
            pkt_d[1] = {2'b00, sp_q, se_q};
          end
          default: begin
            len_d    = 2'd0;
            pkt_d[0] = hdr(2'd3, 2'd0);
          end
        endcase
`ifdef UART_TX_CHKSUM_EN
        // Unused payload slots are zero, so XOR over all four is the checksum.
        chk_d = pkt_d[0] ^ pkt_d[1] ^ pkt_d[2] ^ pkt_d[3];
`endif
      end
      SEND: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = pkt_q[idx_q];
          if (idx_q == len_q) begin
`ifdef UART_TX_CHKSUM_EN
            state_d = CHK;
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
`ifdef UART_TX_CHKSUM_EN
      CHK: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = chk_q;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, pending flags, latches and counters; reset aborts any packet at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      kx_q    <= '0;  ky_q <= '0;
      sx_q    <= '0;  sy_q <= '0;
      sp_q    <= '0;  se_q <= '0;
      rr_q    <= 2'd0;
      idx_q   <= '0;
      len_q   <= '0;
      pkt_q   <= '0;
`ifdef UART_TX_CHKSUM_EN
      chk_q   <= '0;
`endif
      ovr_q   <= '0;
      hb_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      kx_q    <= kx_d;  ky_q <= ky_d;
      sx_q    <= sx_d;  sy_q <= sy_d;
      sp_q    <= sp_d;  se_q <= se_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pkt_q   <= pkt_d;
`ifdef UART_TX_CHKSUM_EN
      chk_q   <= chk_d;
`endif
      ovr_q   <= ovr_d;
      hb_q    <= hb_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed vector table, hand-written corner
// sequences and randomized traffic checked against a packet-level model.
module tb_uart_tx_sched;
  localparam int HB = 16;

  logic        clk = 1'b0;
  logic        rst, enable, tx_full;
  logic        keeper_req, shot_req, score_req;
  logic [11:0] keeper_x, keeper_y, shot_x, shot_y;
  logic [2:0]  score_player, score_enemy;
  logic        wr_uart, busy;
  logic [7:0]  w_data;
  logic [7:0]  overrun_cnt;

  uart_tx_sched #(.HB_PERIOD(HB), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .keeper_req(keeper_req), .keeper_x(keeper_x), .keeper_y(keeper_y),
    .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
    .score_req(score_req), .score_player(score_player), .score_enemy(score_enemy),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_viol = 0;
  logic [7:0] cap[$];
  logic s_wr, s_busy;
  logic [7:0] s_data;

  // Reference model: pending messages, round-robin pointer, bytes of the packet in flight.
  bit   [3:0]  m_pend;
  logic [11:0] m_x[4], m_y[4];
  int          m_sp, m_se, m_rr, m_ovr, m_hb, m_mode; // mode: 0 idle, 1 loading, 2 sending
  logic [7:0]  m_q[$];

  typedef struct {
    logic        kreq;
    logic [11:0] kx, ky;
    logic        full;
    logic        ewr;
    logic [7:0]  edata;
    logic        ebusy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0; m_sp = 0; m_se = 0; m_rr = 0; m_ovr = 0; m_hb = 0; m_mode = 0;
    for (int i = 0; i < 4; i++) begin m_x[i] = '0; m_y[i] = '0; end
    m_q.delete();
  endfunction

  function automatic void build(input int s);
    int x, y, len, c;
    m_q.delete();
    len = (s < 2) ? 3 : (s == 2) ? 1 : 0;
    m_q.push_back(8'('hA0 + s * 4 + len));
    if (s < 2) begin
      x = int'(m_x[s]); y = int'(m_y[s]);
      m_q.push_back(8'(x / 16));
      m_q.push_back(8'((x % 16) * 16 + y / 256));
      m_q.push_back(8'(y % 256));
    end else if (s == 2) begin
      m_q.push_back(8'(m_sp * 8 + m_se));
    end
`ifdef UART_TX_CHKSUM_EN
    c = 0;
    foreach (m_q[i]) c = c ^ int'(m_q[i]);
    m_q.push_back(8'(c));
`else
    c = 0;
`endif
  endfunction

  function automatic void capture(input int i);
    if (m_pend[i] && i < 3) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
    m_pend[i] = 1'b1;
  endfunction

  function automatic void model_step();
    int g, nmode;
    bit anyp;
    anyp  = (m_pend != 0);
    nmode = m_mode;
    g     = -1;
    if (m_mode == 1) begin
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      if (g >= 0) begin
        build(g);
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % 4;
      end
      nmode = 2;
    end else if (m_mode == 2) begin
      if (!tx_full) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) nmode = 0;
      end
    end else if (anyp) begin
      nmode = 1;
    end
    if (enable) begin
      if (keeper_req) begin capture(0); m_x[0] = keeper_x; m_y[0] = keeper_y; end
      if (shot_req)   begin capture(1); m_x[1] = shot_x;   m_y[1] = shot_y;   end
      if (score_req)  begin capture(2); m_sp = int'(score_player); m_se = int'(score_enemy); end
      if (m_hb == HB - 1) begin m_hb = 0; m_pend[3] = 1'b1; end
      else m_hb++;
    end else begin
      m_hb = 0;
    end
    m_mode = nmode;
  endfunction

  // One clock: compare against the model at negedge, then advance it at posedge.
  task automatic cycle();
    int ew, ed, eb;
    eb = (m_mode != 0);
    ew = (m_mode == 2 && !tx_full);
    ed = (ew && m_q.size() > 0) ? int'(m_q[0]) : 0;
    @(negedge clk);
    s_wr = wr_uart; s_data = w_data; s_busy = busy;
    chk("model_wr", int'(wr_uart), ew);
    chk("model_data", int'(w_data), ed);
    chk("model_busy", int'(busy), eb);
    chk("model_ovr", int'(overrun_cnt), m_ovr);
    if (wr_uart) cap.push_back(w_data);
    if (wr_uart && tx_full) wr_viol++;
    @(posedge clk);
    model_step();
    #1;
    keeper_req = 1'b0; shot_req = 1'b0; score_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    keeper_req = 1'b0; shot_req = 1'b0; score_req = 1'b0;
    #1;
    chk("reset_wr", int'(wr_uart), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_data", int'(w_data), 0);
    chk("reset_ovr", int'(overrun_cnt), 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    while (cap.size() < n && budget > 0) begin cycle(); budget--; end
  endtask

  task automatic cmp_bytes(input string name, input int exp[$]);
    chk({name, "_count"}, (cap.size() >= exp.size()) ? exp.size() : cap.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", name, i), (i < cap.size()) ? int'(cap[i]) : -1, exp[i]);
  endtask

  task automatic add(input logic kr, input int kx, input int ky, input logic f,
                     input logic ew, input int ed, input logic eb);
    vec_t v;
    v.kreq = kr; v.kx = 12'(kx); v.ky = 12'(ky); v.full = f;
    v.ewr = ew; v.edata = 8'(ed); v.ebusy = eb;
    tbl.push_back(v);
  endtask

  initial begin
    int exp[$];
    int wrows[$];
    int wdat[$];
    // Keeper packet with free FIFO, then a second one with FIFO stalls.
    add(1, 'h3A5, 'h1C7, 0, 0, 'h00, 0);
    add(0, 0, 0, 0, 0, 'h00, 0);
    add(0, 0, 0, 0, 0, 'h00, 1);
    add(0, 0, 0, 0, 1, 'hA3, 1);
    add(0, 0, 0, 0, 1, 'h3A, 1);
    add(0, 0, 0, 0, 1, 'h51, 1);
    add(0, 0, 0, 0, 1, 'hC7, 1);
`ifdef UART_TX_CHKSUM_EN
    add(0, 0, 0, 0, 1, 'h0F, 1);
`endif
    add(1, 'hFFF, 'h000, 0, 0, 'h00, 0);
    add(0, 0, 0, 0, 0, 'h00, 0);
    add(0, 0, 0, 0, 0, 'h00, 1);
    add(0, 0, 0, 1, 0, 'h00, 1);
    add(0, 0, 0, 0, 1, 'hA3, 1);
    add(0, 0, 0, 0, 1, 'hFF, 1);
    add(0, 0, 0, 1, 0, 'h00, 1);
    add(0, 0, 0, 0, 1, 'hF0, 1);
    add(0, 0, 0, 0, 1, 'h00, 1);
`ifdef UART_TX_CHKSUM_EN
    add(0, 0, 0, 1, 0, 'h00, 1);
    add(0, 0, 0, 0, 1, 'hAC, 1);
`endif
    add(0, 0, 0, 0, 0, 'h00, 0);

    enable = 1'b1; tx_full = 1'b0;
    keeper_x = '0; keeper_y = '0; shot_x = '0; shot_y = '0;
    score_player = '0; score_enemy = '0;
    do_reset();

    // Vector table.
    foreach (tbl[r]) begin
      keeper_req = tbl[r].kreq; keeper_x = tbl[r].kx; keeper_y = tbl[r].ky;
      tx_full = tbl[r].full;
      cycle();
      chk($sformatf("tbl%0d_wr", r), int'(s_wr), int'(tbl[r].ewr));
      chk($sformatf("tbl%0d_data", r), int'(s_data), int'(tbl[r].edata));
      chk($sformatf("tbl%0d_busy", r), int'(s_busy), int'(tbl[r].ebusy));
    end

    // Three simultaneous requests leave in round-robin order.
    do_reset(); tx_full = 1'b0;
    keeper_req = 1; keeper_x = 12'h123; keeper_y = 12'h456;
    shot_req = 1;   shot_x = 12'hABC;   shot_y = 12'hDEF;
    score_req = 1;  score_player = 3'd3; score_enemy = 3'd2;
    cap.delete();
`ifdef UART_TX_CHKSUM_EN
    exp = '{'hA3, 'h12, 'h34, 'h56, 'hD3, 'hA7, 'hAB, 'hCD, 'hEF, 'h2E, 'hA9, 'h1A, 'hB3};
`else
    exp = '{'hA3, 'h12, 'h34, 'h56, 'hA7, 'hAB, 'hCD, 'hEF, 'hA9, 'h1A};
`endif
    run_until(exp.size(), 80);
    cmp_bytes("multi", exp);
    chk("multi_ovr", int'(overrun_cnt), 0);

    // Keeper overwritten while a stalled shot packet is in flight.
    do_reset(); tx_full = 1'b0;
    shot_req = 1; shot_x = 12'h111; shot_y = 12'h222;
    cycle(); cycle(); cycle();
    tx_full = 1'b1;
    keeper_req = 1; keeper_x = 12'h001; keeper_y = 12'h002;
    cycle(); cycle();
    keeper_req = 1; keeper_x = 12'h3A5; keeper_y = 12'h1C7;
    cycle(); cycle(); cycle();
    chk("ovr_after_overwrite", int'(overrun_cnt), 1);
    tx_full = 1'b0;
    cap.delete();
`ifdef UART_TX_CHKSUM_EN
    exp = '{'hA7, 'h11, 'h12, 'h22, 'h86, 'hA3, 'h3A, 'h51, 'hC7, 'h0F};
`else
    exp = '{'hA7, 'h11, 'h12, 'h22, 'hA3, 'h3A, 'h51, 'hC7};
`endif
    run_until(exp.size(), 60);
    cmp_bytes("ovr", exp);
    chk("ovr_final", int'(overrun_cnt), 1);

    // tx_full toggling every cycle during a shot packet.
    do_reset(); tx_full = 1'b0;
    shot_req = 1; shot_x = 12'h5A5; shot_y = 12'h3C3;
    cap.delete(); wr_viol = 0;
    for (int i = 0; i < 14; i++) begin tx_full = i[0]; cycle(); end
    tx_full = 1'b0;
`ifdef UART_TX_CHKSUM_EN
    exp = '{'hA7, 'h5A, 'h53, 'hC3, 'h6D};
`else
    exp = '{'hA7, 'h5A, 'h53, 'hC3};
`endif
    chk("toggle_writes", cap.size(), exp.size());
    cmp_bytes("toggle", exp);
    chk("toggle_wr_while_full", wr_viol, 0);

    // Heartbeat: silent while disabled, then every HB cycles.
    enable = 1'b0;
    do_reset();
    cap.delete();
    for (int i = 0; i < 40; i++) cycle();
    chk("hb_disabled_writes", cap.size(), 0);
    enable = 1'b1;
    for (int r = 0; r < 37; r++) begin
      cycle();
      if (s_wr) begin wrows.push_back(r); wdat.push_back(int'(s_data)); end
    end
`ifdef UART_TX_CHKSUM_EN
    exp = '{18, 19, 34, 35};
`else
    exp = '{18, 34};
`endif
    chk("hb_write_count", wrows.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("hb_row%0d", i), (i < wrows.size()) ? wrows[i] : -1, exp[i]);
      chk($sformatf("hb_data%0d", i), (i < wdat.size()) ? wdat[i] : -1, 'hAC);
    end

    // Reset in the middle of a payload, then a fresh score packet.
    do_reset(); tx_full = 1'b0;
    keeper_req = 1; keeper_x = 12'h3A5; keeper_y = 12'h1C7;
    cycle(); cycle(); cycle(); cycle();
    chk("pre_reset_wr", int'(wr_uart), 1);
    do_reset();
    score_req = 1; score_player = 3'd0; score_enemy = 3'd0;
    cap.delete();
`ifdef UART_TX_CHKSUM_EN
    exp = '{'hA9, 'h00, 'hA9};
`else
    exp = '{'hA9, 'h00};
`endif
    run_until(exp.size(), 20);
    cmp_bytes("post_reset", exp);
    chk("post_reset_ovr", int'(overrun_cnt), 0);

    // Randomized traffic against the model.
    enable = 1'b1;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      enable       = ($urandom_range(0, 9) != 0);
      tx_full      = ($urandom_range(0, 2) == 0);
      keeper_req   = ($urandom_range(0, 5) == 0);
      shot_req     = ($urandom_range(0, 5) == 0);
      score_req    = ($urandom_range(0, 7) == 0);
      keeper_x     = 12'($urandom); keeper_y = 12'($urandom);
      shot_x       = 12'($urandom); shot_y   = 12'($urandom);
      score_player = 3'($urandom);  score_enemy = 3'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
